// File: rtl/riscmakers_icache_refill.sv
// Icache refill engine: splits a line fill or 64-bit non-cacheable fetch into
// single-beat reads on a req/gnt/rvalid bus and returns the assembled line.
module riscmakers_icache_refill #(
    parameter int PADDR_WIDTH = 34,
    parameter int LINE_WIDTH  = 128,
    parameter int BEAT_WIDTH  = 32,
    parameter int TID_WIDTH   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ack_o,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic                   req_nc_i,
    input  logic [TID_WIDTH-1:0]   req_tid_i,
    output logic                   rtrn_vld_o,
    output logic [TID_WIDTH-1:0]   rtrn_tid_o,
    output logic [LINE_WIDTH-1:0]  rtrn_data_o,
    output logic                   rtrn_err_o,
    output logic                   mem_req_o,
    output logic [PADDR_WIDTH-1:0] mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [BEAT_WIDTH-1:0]  mem_rdata_i,
    input  logic                   mem_err_i
);

    localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int NC_BEATS  = 64 / BEAT_WIDTH;
    localparam int LINE_OFF  = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_OFF  = $clog2(BEAT_WIDTH / 8);
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SLOT_W    = (LINE_WIDTH > 64) ? $clog2(LINE_WIDTH / 64) : 1;

    localparam logic [PADDR_WIDTH-1:0] LINE_MASK = ~PADDR_WIDTH'((LINE_WIDTH / 8) - 1);
    localparam logic [PADDR_WIDTH-1:0] NC_MASK   = ~PADDR_WIDTH'(7);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDATA, RESPOND} state_t;

    state_t                 state_reg;
    logic [PADDR_WIDTH-1:0] base_reg;
    logic                   nc_reg;
    logic [SLOT_W-1:0]      slot_reg;
    logic [TID_WIDTH-1:0]   tid_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [LINE_WIDTH-1:0]  line_reg;
    logic                   err_reg;

    logic [PADDR_WIDTH-1:0] req_base;
    logic [SLOT_W-1:0]      req_slot;
    logic [CNT_W-1:0]       beat_pos;
    logic                   last_beat;

    // A 64-bit line has only one slot, so there are no slot bits to extract.
    generate
        if (LINE_WIDTH > 64) begin : gen_slot
            assign req_slot = req_paddr_i[LINE_OFF-1:3];
        end else begin : gen_no_slot
            assign req_slot = '0;
        end
    endgenerate

    assign req_base  = req_paddr_i & (req_nc_i ? NC_MASK : LINE_MASK);
    assign beat_pos  = nc_reg ? (CNT_W'(slot_reg * NC_BEATS) + cnt_reg) : cnt_reg;
    assign last_beat = (cnt_reg == (nc_reg ? CNT_W'(NC_BEATS - 1) : CNT_W'(NUM_BEATS - 1)));

    assign req_ack_o   = (state_reg == IDLE) && req_valid_i;
    assign mem_req_o   = (state_reg == ISSUE);
    assign mem_addr_o  = base_reg + (PADDR_WIDTH'(cnt_reg) << BEAT_OFF);
    assign rtrn_vld_o  = (state_reg == RESPOND);
    assign rtrn_tid_o  = tid_reg;
    assign rtrn_data_o = line_reg;
    assign rtrn_err_o  = err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            nc_reg    <= 1'b0;
            slot_reg  <= '0;
            tid_reg   <= '0;
            cnt_reg   <= '0;
            line_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        base_reg  <= req_base;
                        nc_reg    <= req_nc_i;
                        slot_reg  <= req_slot;
                        tid_reg   <= req_tid_i;
                        cnt_reg   <= '0;
                        line_reg  <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        state_reg <= WAIT_RDATA;
                    end
                end
                WAIT_RDATA: begin
                    // Errors are accumulated but never cut the burst short.
                    if (mem_rvalid_i) begin
                        line_reg[beat_pos*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
                        err_reg <= err_reg | mem_err_i;
                        if (last_beat) begin
                            state_reg <= RESPOND;
                        end else begin
                            cnt_reg   <= cnt_reg + 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                RESPOND: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscmakers_icache_refill.sv
// Directed bench for the icache refill engine: a vector table run through a
// configurable memory responder, plus reset-abort and back-to-back sequences.
module tb_riscmakers_icache_refill;

    logic         clk_i;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ack_o;
    logic [33:0]  req_paddr_i;
    logic         req_nc_i;
    logic [1:0]   req_tid_i;
    logic         rtrn_vld_o;
    logic [1:0]   rtrn_tid_o;
    logic [127:0] rtrn_data_o;
    logic         rtrn_err_o;
    logic         mem_req_o;
    logic [33:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic         mem_err_i;

    riscmakers_icache_refill dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ack_o    (req_ack_o),
        .req_paddr_i  (req_paddr_i),
        .req_nc_i     (req_nc_i),
        .req_tid_i    (req_tid_i),
        .rtrn_vld_o   (rtrn_vld_o),
        .rtrn_tid_o   (rtrn_tid_o),
        .rtrn_data_o  (rtrn_data_o),
        .rtrn_err_o   (rtrn_err_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [33:0]      paddr;
        bit               nc;
        logic [1:0]       tid;
        logic [3:0][31:0] d;
        int               err_beat;
        int               stall;
        int               delay;
        logic [127:0]     exp_data;
        bit               exp_err;
        int               exp_lat;
        logic [33:0]      exp_base;
        int               n;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    // memory responder state
    int               gnt_stall = 0;
    int               rv_delay = 1;
    int               err_beat = -1;
    logic [3:0][31:0] beat_data;
    int               gnt_count = 0;
    int               stall_cnt = 0;
    int               vld_count = 0;
    logic [33:0]      addr_log [8];
    bit               pend = 0;
    int               pend_cnt = 0;
    logic [31:0]      pend_data;
    bit               pend_err = 0;
    bit               prev_req = 0;
    bit               prev_gnt = 0;
    logic [33:0]      prev_addr = '0;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic configure(input logic [3:0][31:0] d, input int eb, input int st, input int dl);
        beat_data = d;
        err_beat  = eb;
        gnt_stall = st;
        rv_delay  = dl;
        gnt_count = 0;
        stall_cnt = 0;
    endtask

    // One clock: advance, then play the memory side for the new cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_data;
                mem_err_i    = pend_err;
                pend         = 0;
            end
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
            if (prev_req && !prev_gnt)
                chk("addr_stable", 128'(mem_addr_o), 128'(prev_addr));
            if (stall_cnt < gnt_stall) begin
                stall_cnt++;
            end else begin
                mem_gnt_i = 1'b1;
                stall_cnt = 0;
                if (gnt_count < 8) addr_log[gnt_count] = mem_addr_o;
                pend      = 1;
                pend_cnt  = rv_delay;
                pend_data = beat_data[gnt_count % 4];
                pend_err  = (gnt_count == err_beat);
                gnt_count++;
            end
        end
        prev_req  = mem_req_o;
        prev_gnt  = mem_gnt_i;
        prev_addr = mem_addr_o;
        if (rtrn_vld_o) vld_count++;
    endtask

    task automatic start_req(input logic [33:0] paddr, input bit nc, input logic [1:0] tid);
        req_valid_i = 1'b1;
        req_paddr_i = paddr;
        req_nc_i    = nc;
        req_tid_i   = tid;
        vld_count   = 0;
        #1;
        chk("ack", 128'(req_ack_o), 128'(1));
        c0 = cyc;
    endtask

    task automatic wait_rtrn(input logic [127:0] exp_data, input logic [1:0] exp_tid,
                             input bit exp_err, input int exp_lat, input bit drop);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (drop) req_valid_i = 1'b0;
            #1;
            chk("ack_low_busy", 128'(req_ack_o), 128'(0));
            if (rtrn_vld_o) begin
                got = 1;
                chk("rtrn_data", rtrn_data_o, exp_data);
                chk("rtrn_tid", 128'(rtrn_tid_o), 128'(exp_tid));
                chk("rtrn_err", 128'(rtrn_err_o), 128'(exp_err));
                if (exp_lat >= 0) chk("latency", 128'(cyc - c0), 128'(exp_lat));
            end
        end
        if (!got) chk("rtrn_timeout", 128'(0), 128'(1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        configure(v.d, v.err_beat, v.stall, v.delay);
        start_req(v.paddr, v.nc, v.tid);
        wait_rtrn(v.exp_data, v.tid, v.exp_err, v.exp_lat, 1'b1);
        repeat (3) tick();
        chk("vld_pulses", 128'(vld_count), 128'(1));
        chk("grants", 128'(gnt_count), 128'(v.n));
        for (int k = 0; k < v.n && k < 8; k++)
            chk("beat_addr", 128'(addr_log[k]), 128'(v.exp_base + 34'(4 * k)));
        $display("vec %0d paddr=%h nc=%0d tid=%0d data=%h err=%0d", idx, v.paddr, v.nc,
                 v.tid, rtrn_data_o, rtrn_err_o);
    endtask

    initial begin
        vec_t pr;
        bit   found;

        vecs[0] = '{34'h0_8000_0014, 0, 2'd1, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1,
                    128'h00000044_00000033_00000022_00000011, 0, 9, 34'h0_8000_0010, 4};
        vecs[1] = '{34'h0_1000_000C, 1, 2'd2, {32'h0, 32'h0, 32'hBB, 32'hAA}, -1, 0, 1,
                    128'h000000BB_000000AA_00000000_00000000, 0, 5, 34'h0_1000_0008, 2};
        vecs[2] = '{34'h2_0000_0038, 0, 2'd3,
                    {32'hF0F0_0004, 32'hF0F0_0003, 32'hF0F0_0002, 32'hF0F0_0001}, -1, 3, 2,
                    128'hF0F00004_F0F00003_F0F00002_F0F00001, 0, 25, 34'h2_0000_0030, 4};
        vecs[3] = '{34'h0_0000_1000, 0, 2'd0, {32'h8, 32'h7, 32'h6, 32'h5}, 2, 0, 1,
                    128'h00000008_00000007_00000006_00000005, 1, 9, 34'h0_0000_1000, 4};
        vecs[4] = '{34'h0_0000_1004, 1, 2'd1, {32'h0, 32'h0, 32'hD, 32'hC}, -1, 0, 1,
                    128'h00000000_00000000_0000000D_0000000C, 0, 5, 34'h0_0000_1000, 2};
        vecs[5] = '{34'h3_FFFF_FFFF, 0, 2'd2, {32'h4, 32'h3, 32'h2, 32'h1}, -1, 0, 1,
                    128'h00000004_00000003_00000002_00000001, 0, 9, 34'h3_FFFF_FFF0, 4};

        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_paddr_i  = '0;
        req_nc_i     = 1'b0;
        req_tid_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
        beat_data    = '0;
        pend_data    = '0;

        repeat (3) tick();
        #1;
        chk("rst_ack", 128'(req_ack_o), 128'(0));
        chk("rst_vld", 128'(rtrn_vld_o), 128'(0));
        chk("rst_err", 128'(rtrn_err_o), 128'(0));
        chk("rst_mem_req", 128'(mem_req_o), 128'(0));
        chk("rst_data", rtrn_data_o, 128'(0));
        chk("rst_tid", 128'(rtrn_tid_o), 128'(0));
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while waiting for beat 1 data; the in-flight rvalid then lands in IDLE.
        configure({4{32'h9999_9999}}, -1, 0, 2);
        start_req(34'h0_4000_0000, 1'b0, 2'd3);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            req_valid_i = 1'b0;
            #1;
            if (gnt_count == 2 && !mem_req_o) found = 1;
        end
        if (!found) chk("rst_seq_timeout", 128'(0), 128'(1));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("midrst_mem_req", 128'(mem_req_o), 128'(0));
        chk("midrst_vld", 128'(rtrn_vld_o), 128'(0));
        chk("midrst_data", rtrn_data_o, 128'(0));
        chk("midrst_tid", 128'(rtrn_tid_o), 128'(0));
        chk("midrst_stray_rvalid_seen", 128'(mem_rvalid_i), 128'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("stray_idle_req", 128'(mem_req_o), 128'(0));
            chk("stray_idle_vld", 128'(rtrn_vld_o), 128'(0));
        end
        $display("reset-abort sequence done, gnt_count=%0d", gnt_count);
        pr = '{34'h0_4000_0008, 1, 2'd2, {32'h0, 32'h0, 32'h66, 32'h55}, -1, 0, 1,
               128'h00000066_00000055_00000000_00000000, 0, 5, 34'h0_4000_0008, 2};
        run_vec(pr, 6);

        // Back-to-back: valid stays high, second request presented right after first ack.
        configure({32'hA4, 32'hA3, 32'hA2, 32'hA1}, -1, 0, 1);
        start_req(34'h0_0000_0100, 1'b0, 2'd1);
        tick();
        req_paddr_i = 34'h0_0000_0208;
        req_nc_i    = 1'b1;
        req_tid_i   = 2'd2;
        #1;
        chk("b2b_ack_busy", 128'(req_ack_o), 128'(0));
        wait_rtrn(128'h000000A4_000000A3_000000A2_000000A1, 2'd1, 1'b0, 9, 1'b0);
        $display("b2b first tid=%0d data=%h", rtrn_tid_o, rtrn_data_o);
        configure({32'h0, 32'h0, 32'hB2, 32'hB1}, -1, 0, 1);
        tick();
        #1;
        chk("b2b_ack_after_respond", 128'(req_ack_o), 128'(1));
        c0 = cyc;
        vld_count = 0;
        wait_rtrn(128'h000000B2_000000B1_00000000_00000000, 2'd2, 1'b0, 5, 1'b1);
        $display("b2b second tid=%0d data=%h", rtrn_tid_o, rtrn_data_o);
        repeat (3) tick();
        chk("b2b_grants", 128'(gnt_count), 128'(2));
        chk("b2b_vld_pulses", 128'(vld_count), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscmakers_icache_refill.md
Name: riscmakers_icache_refill

Overview:
Memory-side refill engine directly downstream of the RISC Makers instruction cache. Accepts one line-fill or non-cacheable fetch request at a time from the icache miss port. Splits the request into single-beat reads on a simple req/gnt/rvalid memory bus and assembles the beats into a full line. Returns the line to the icache as a single IFILL_ACK return pulse.

Parameters:
PADDR_WIDTH, 34, physical address width
LINE_WIDTH, 128, icache line width in bits; must be a multiple of 64
BEAT_WIDTH, 32, memory bus data width; must be 32 or 64
TID_WIDTH, 2, transaction ID width; must match the cache ID width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  icache fill request; held high until acked
req_ack_o  out  1  one-cycle acknowledge; request is latched in the same cycle
req_paddr_i  in  PADDR_WIDTH  request physical address
req_nc_i  in  1  non-cacheable request: fetch 64 bits instead of a full line
req_tid_i  in  TID_WIDTH  request transaction ID
rtrn_vld_o  out  1  one-cycle return pulse; type is implied IFILL_ACK
rtrn_tid_o  out  TID_WIDTH  echo of the latched request ID
rtrn_data_o  out  LINE_WIDTH  assembled line data
rtrn_err_o  out  1  at least one beat of this request returned an error
mem_req_o  out  1  beat read request; held until granted
mem_addr_o  out  PADDR_WIDTH  beat address, BEAT_WIDTH/8-aligned
mem_gnt_i  in  1  grant for the current beat
mem_rvalid_i  in  1  beat data valid; arrives at least 1 cycle after its grant
mem_rdata_i  in  BEAT_WIDTH  beat data
mem_err_i  in  1  bus error for the beat; qualified by mem_rvalid_i

Behaviour:
- Reset values: req_ack_o=0, rtrn_vld_o=0, rtrn_err_o=0, mem_req_o=0, rtrn_data_o=0, rtrn_tid_o=0, state=IDLE, beat counter=0.
- Reset mid-operation aborts the transfer and returns to IDLE. An rvalid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT_RDATA, RESPOND.
- IDLE:
  - When req_valid_i=1: req_ack_o=1 combinationally.
  - Latch paddr, nc and tid; clear the line buffer, err flag and beat counter; go to ISSUE.
  - req_ack_o is never asserted outside IDLE.
- Beat count N:
  - cacheable: LINE_WIDTH/BEAT_WIDTH
  - nc: 64/BEAT_WIDTH
- Base address:
  - cacheable: paddr with the low log2(LINE_WIDTH/8) bits cleared
  - nc: paddr with bits [2:0] cleared
  - These low bits are forced to zero regardless of the input.
- mem_addr_o = base + k*(BEAT_WIDTH/8), where k is the beat counter.
- ISSUE:
  - mem_req_o=1.
  - mem_gnt_i=1 -> WAIT_RDATA. Otherwise stay, with address stable.
- WAIT_RDATA:
  - mem_req_o=0. Only one beat is outstanding at a time.
  - On mem_rvalid_i: write the beat into the line buffer and OR mem_err_i into the err flag.
  - If k=N-1 -> RESPOND. Otherwise k+1 -> ISSUE.
- Beat placement:
  - cacheable: beat k goes to bits [k*BEAT_WIDTH +: BEAT_WIDTH].
  - nc: beat k goes to bits [64*s + k*BEAT_WIDTH +: BEAT_WIDTH], where s = paddr[log2(LINE_WIDTH/8)-1:3]. All other bits stay 0.
- RESPOND:
  - rtrn_vld_o=1 for exactly one cycle, with data, tid and err from registers; then go to IDLE.
  - A new request cannot be acked in the RESPOND cycle.
- Latency, zero-wait memory (gnt same cycle, rvalid 1 cycle after gnt): ack at cycle 0, rtrn_vld_o at cycle 2N+1.
  - cacheable 128/32: cycle 9
  - nc: cycle 5
- mem_rvalid_i in IDLE, ISSUE or RESPOND is spurious and ignored.
- An error does not abort the transfer: all N beats are still fetched.
- No kill input. The icache always consumes or discards the return itself.

Test Plan:
- Cacheable fill, paddr=0x0_8000_0014, tid=1, zero-wait memory:
  - mem_addr_o sequence 0x8000_0010, 14, 18, 1C; rdata 0x11,0x22,0x33,0x44.
  - rtrn_vld_o at cycle 9; rtrn_data_o=0x00000044_00000033_00000022_00000011; tid=1; err=0.
- nc fetch, paddr=0x0_1000_000C:
  - 2 beats at 0x1000_0008 and 0x1000_000C; rdata 0xAA, 0xBB.
  - rtrn_data_o=0x000000BB_000000AA_0000000000000000 (slot s=1); rtrn_vld_o at cycle 5.
- Grant stalls of 3 cycles per beat and rvalid delayed 2 cycles:
  - mem_addr_o is stable while mem_req_o=1.
  - Exactly 4 grants occur and exactly one rtrn_vld_o pulse.
- mem_err_i=1 on beat 2 only: all 4 beats are fetched; rtrn_err_o=1 with the pulse. The next request returns err=0.
- rst_i asserted in WAIT_RDATA of beat 1:
  - The next cycle shows IDLE outputs; a later stray rvalid is ignored.
  - A new request completes correctly with a clean buffer.
- Back-to-back requests, req_valid_i held high:
  - The second ack comes in the cycle after the RESPOND pulse, never with it.
  - The tid is echoed per request.
